// File: rtl/counter_pkg.sv
// Shared constants for the counter library (down_counter, up_counter, tick_prescaler).
package counter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_EXPIRED = 2'd2;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_PRESCALE = 1;

  // A one-bit counter is kept even when PRESCALE is 1 so the port widths never collapse to zero.
  function automatic int prescale_cnt_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE, emitting a one-cycle tick on the last cycle of each period.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = prescale_cnt_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  // clear suppresses the tick so a load never coincides with a step.
  assign tick   = enable && !clear && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter / interval timer with terminal-count pulse and sticky expiry flag.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to reload the start value at terminal count (periodic timer).
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             done,
  output logic             expired
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             r_expired;
  logic             w_count_en;
  logic             w_tick;
  logic             w_terminal;
  logic             w_auto;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= load_value;
    end
  end

  // A zero reload value degrades to one-shot behaviour.
  assign w_auto = (r_reload != '0);
`else
  assign w_auto = 1'b0;
`endif

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (w_count_en),
    .clear  (load),
    .tick   (w_tick)
  );

  assign w_terminal = w_tick && (r_out == WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_EXPIRED: begin
        if (load) begin
          w_next_state = (load_value != '0) ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (load) begin
          w_next_state = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else if (w_terminal && !w_auto) begin
          w_next_state = ST_EXPIRED;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_count_en = enable && (r_state == ST_RUN);
    zero       = (r_out == '0);
    out        = r_out;
    done       = r_done;
    expired    = r_expired;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else if (load) begin
      r_out     <= load_value;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else if (w_terminal) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_out     <= w_auto ? r_reload : '0;
`else
      r_out     <= '0;
`endif
      r_done    <= 1'b1;
      r_expired <= 1'b1;
    end else begin
      if (w_tick) begin
        r_out <= r_out - WIDTH'(1);
      end
      r_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Randomized and directed bench for down_counter; two instances (PRESCALE 1 and 3) share stimulus.
module tb_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] load_value;

  logic [3:0] out_w     [2];
  logic       zero_w    [2];
  logic       done_w    [2];
  logic       expired_w [2];

  int checks = 0;
  int errors = 0;

  // Reference model: remaining count, enabled cycles into the current step, flags.
  int P [2] = '{1, 3};
  int m_out [2];
  int m_phase [2];
  int m_rel [2];
  bit m_run [2];
  bit m_done [2];
  bit m_exp [2];

  always #5 clk = ~clk;

  down_counter #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .out(out_w[0]), .zero(zero_w[0]), .done(done_w[0]), .expired(expired_w[0])
  );

  down_counter #(.WIDTH(4), .PRESCALE(3)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .out(out_w[1]), .zero(zero_w[1]), .done(done_w[1]), .expired(expired_w[1])
  );

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 0; m_phase[k] = 0; m_rel[k] = 0;
      m_run[k] = 0; m_done[k] = 0; m_exp[k] = 0;
    end
  endfunction

  function automatic bit auto_reload_on();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step(int k);
    if (load) begin
      m_out[k] = int'(load_value); m_rel[k] = int'(load_value);
      m_phase[k] = 0; m_done[k] = 0; m_exp[k] = 0;
      m_run[k] = (load_value != 0);
    end else begin
      m_done[k] = 0;
      if (enable && m_run[k]) begin
        m_phase[k]++;
        if (m_phase[k] == P[k]) begin
          m_phase[k] = 0;
          if (m_out[k] == 1) begin
            m_done[k] = 1; m_exp[k] = 1;
            if (auto_reload_on() && m_rel[k] != 0) m_out[k] = m_rel[k];
            else begin m_out[k] = 0; m_run[k] = 0; end
          end else begin
            m_out[k] = m_out[k] - 1;
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all(input string phase);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.out[p%0d]", phase, P[k]),     16'(out_w[k]),     16'(m_out[k]));
      check($sformatf("%s.zero[p%0d]", phase, P[k]),    16'(zero_w[k]),    16'(m_out[k] == 0));
      check($sformatf("%s.done[p%0d]", phase, P[k]),    16'(done_w[k]),    16'(m_done[k]));
      check($sformatf("%s.expired[p%0d]", phase, P[k]), 16'(expired_w[k]), 16'(m_exp[k]));
    end
  endtask

  task automatic step(input string phase);
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    compare_all(phase);
    $display("step %-8s t=%0t en=%0b ld=%0b lv=%0d out1=%0d out3=%0d done=%0b%0b exp=%0b%0b",
             phase, $time, enable, load, load_value, out_w[0], out_w[1],
             done_w[0], done_w[1], expired_w[0], expired_w[1]);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = 4'd0;
    model_reset();
    #20;
    reset = 1'b0;
    #1;
    compare_all("reset");
    repeat (3) step("idle");

    load = 1'b1; load_value = 4'd5; step("load5");
    load = 1'b0; enable = 1'b1;
    repeat (8) step("run5");

    load = 1'b1; load_value = 4'd6; step("load6");
    load = 1'b0;
    repeat (3) step("run6");
    enable = 1'b0;
    repeat (3) step("hold6");
    enable = 1'b1;
    repeat (6) step("resume6");

    load = 1'b1; load_value = 4'd2; step("load2");
    load = 1'b0;
    repeat (9) step("pre2");

    load = 1'b1; load_value = 4'd2; step("ldterm");
    load = 1'b0; step("ldterm");
    load = 1'b1; load_value = 4'd9; step("ld9tick");
    load = 1'b0;
    repeat (3) step("after9");

    load = 1'b1; load_value = 4'd9; step("rst9");
    load = 1'b0;
    repeat (5) step("rst9");
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("asyncrst");
    @(posedge clk);
    #1;
    compare_all("rsthold");
    reset = 1'b0;
    step("postrst");

    load = 1'b1; load_value = 4'd15; step("load15");
    load = 1'b0;
    repeat (18) step("run15");

    load = 1'b1; load_value = 4'd3; step("load3");
    load = 1'b0;
    repeat (12) step("run3");

    for (int i = 0; i < 300; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      load       = ($urandom_range(0, 9) == 0);
      load_value = 4'($urandom_range(0, 15));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
